// File: rtl/mtr_drv.sv
// mtr_drv: dual H-bridge PWM driver with dead-time insertion and latched overcurrent shutdown.
// Define MTR_OVR_SYNC_EN to pass OVR_I inputs through 2-flop synchronizers before qualification.
module mtr_drv #(
    parameter int NONOVERLAP = 32,
    parameter int BLANK      = 128,
    parameter int OVR_LIMIT  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic signed [11:0] lft_spd,
    input  logic signed [11:0] rght_spd,
    input  logic               OVR_I_lft,
    input  logic               OVR_I_rght,
    output logic               PWM1_lft,
    output logic               PWM2_lft,
    output logic               PWM1_rght,
    output logic               PWM2_rght,
    output logic               OVR_I_shtdwn
);
    localparam int BW = $clog2(BLANK + 1);
    localparam int OW = $clog2(OVR_LIMIT + 1);

    logic [10:0]   r_cnt;
    logic [OW-1:0] r_ovr_cnt;
    logic          r_flag, r_shtdwn, w_end, w_shtdwn_nxt;
    logic [1:0]    w_ovr, w_qual, w_pwm1, w_pwm2;
    logic [11:0]   w_spd [2];

    assign w_end        = (r_cnt == 11'd2047);
    assign w_shtdwn_nxt = r_shtdwn || (r_ovr_cnt == OW'(OVR_LIMIT));
    assign w_spd[0]     = lft_spd;
    assign w_spd[1]     = rght_spd;

`ifdef MTR_OVR_SYNC_EN
    logic [1:0] r_ovr_s1, r_ovr_s2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_s1 <= '0;
            r_ovr_s2 <= '0;
        end else begin
            r_ovr_s1 <= {OVR_I_rght, OVR_I_lft};
            r_ovr_s2 <= r_ovr_s1;
        end
    end
    assign w_ovr = r_ovr_s2;
`else
    assign w_ovr = {OVR_I_rght, OVR_I_lft};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_ovr_cnt <= '0;
            r_flag    <= 1'b0;
            r_shtdwn  <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + 11'd1;
            r_shtdwn <= w_shtdwn_nxt;
            if (w_end) begin
                r_ovr_cnt <= (r_flag || |w_qual)
                           ? ((r_ovr_cnt == OW'(OVR_LIMIT)) ? r_ovr_cnt : r_ovr_cnt + 1'b1)
                           : '0;
                r_flag    <= 1'b0;
            end else if (|w_qual) begin
                r_flag <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_mtr
        logic [10:0]   r_duty, w_duty;
        logic [6:0]    r_hi_run, r_lo_run;
        logic [BW-1:0] r_blank;
        logic          r_pwm1, r_pwm2, w_raw_hi;
        // Clamp to [-1024,1023] and offset by 1024: the in-range case is just bit 10 flipped.
        assign w_duty   = (w_spd[g][11] ^ w_spd[g][10]) ? {11{~w_spd[g][11]}}
                                                        : {~w_spd[g][10], w_spd[g][9:0]};
        assign w_raw_hi = (r_cnt < r_duty);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_duty   <= 11'd1024;
                r_hi_run <= '0;
                r_lo_run <= '0;
                r_blank  <= '0;
                r_pwm1   <= 1'b0;
                r_pwm2   <= 1'b0;
            end else begin
                if (w_end) r_duty <= w_duty;
                r_hi_run <= !w_raw_hi ? '0 : (&r_hi_run ? r_hi_run : r_hi_run + 7'd1);
                r_lo_run <= w_raw_hi ? '0 : (&r_lo_run ? r_lo_run : r_lo_run + 7'd1);
                r_pwm1   <= en && !w_shtdwn_nxt && w_raw_hi && (r_hi_run >= 7'(NONOVERLAP));
                r_pwm2   <= en && !w_shtdwn_nxt && !w_raw_hi && (r_lo_run >= 7'(NONOVERLAP));
                r_blank  <= !r_pwm1 ? '0 : ((r_blank == BW'(BLANK)) ? r_blank : r_blank + 1'b1);
            end
        end
        assign w_qual[g] = r_pwm1 && (r_blank == BW'(BLANK)) && w_ovr[g];
        assign w_pwm1[g] = r_pwm1;
        assign w_pwm2[g] = r_pwm2;
    end

    assign PWM1_lft     = w_pwm1[0];
    assign PWM2_lft     = w_pwm2[0];
    assign PWM1_rght    = w_pwm1[1];
    assign PWM2_rght    = w_pwm2[1];
    assign OVR_I_shtdwn = r_shtdwn;
endmodule

// File: tb/tb_mtr_drv.sv
// tb_mtr_drv: directed bench for mtr_drv; period-level pulse counts and overcurrent trip sequence.
// OVR_LIMIT is reduced to 4 so the trip sequence stays short.
module tb_mtr_drv;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, ovr_l = 1'b0, ovr_r = 1'b0;
    logic signed [11:0] lft_spd = '0, rght_spd = '0;
    logic pwm1_l, pwm2_l, pwm1_r, pwm2_r, shtdwn;
    int n_vec = 0, n_err = 0, ov_tot = 0;
    int h1l, h2l, h1r, h2r;

    mtr_drv #(.OVR_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .lft_spd(lft_spd), .rght_spd(rght_spd),
        .OVR_I_lft(ovr_l), .OVR_I_rght(ovr_r),
        .PWM1_lft(pwm1_l), .PWM2_lft(pwm2_l),
        .PWM1_rght(pwm1_r), .PWM2_rght(pwm2_r),
        .OVR_I_shtdwn(shtdwn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        h1l = 0; h2l = 0; h1r = 0; h2r = 0;
    endtask

    // Each tick samples 1 time unit after the active edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            h1l += int'(pwm1_l);
            h2l += int'(pwm2_l);
            h1r += int'(pwm1_r);
            h2r += int'(pwm2_r);
            ov_tot += int'((pwm1_l && pwm2_l) || (pwm1_r && pwm2_r));
        end
    endtask

    // One full period; shutdown checked at offset 2, optional 1-cycle OVR_I_lft pulse at offset off.
    task automatic ovr_period(input int off, input logic exp_sd, input string tag);
        run(2);
        chk(tag, 32'(shtdwn), 32'(exp_sd));
        if (off > 0) begin
            run(off - 2);
            ovr_l = 1'b1;
            run(1);
            ovr_l = 1'b0;
            run(2048 - off - 1);
        end else begin
            run(2046);
        end
    endtask

    initial begin
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm1_l", 32'(pwm1_l), 0);
        chk("rst_pwm2_l", 32'(pwm2_l), 0);
        chk("rst_pwm1_r", 32'(pwm1_r), 0);
        chk("rst_pwm2_r", 32'(pwm2_r), 0);
        chk("rst_shtdwn", 32'(shtdwn), 0);
        @(negedge clk) rst_n = 1'b1;
        // P0: zero speed on both motors
        clr(); run(2048);
        chk("p0_h1l", h1l, 992);
        chk("p0_h2l", h2l, 992);
        chk("p0_h1r", h1r, 992);
        chk("p0_h2r", h2r, 992);
        // P1: speed changes mid-period take effect only next period
        lft_spd = 12'sd2047;
        clr(); run(600);
        rght_spd = 12'sd500;
        run(1448);
        chk("p1_h1l", h1l, 992);
        chk("p1_h1r", h1r, 992);
        // P2: left clamps to duty 2047, right at duty 1524
        lft_spd = -12'sd2048;
        clr(); run(2048);
        chk("p2_h1l", h1l, 2015);
        chk("p2_h2l", h2l, 0);
        chk("p2_h1r", h1r, 1492);
        chk("p2_h2r", h2r, 492);
        // P3/P4: duty 0, PWM2 continuous once the dead-time has elapsed
        clr(); run(2048);
        chk("p3_h1l", h1l, 0);
        chk("p3_h2l", h2l, 2017);
        lft_spd = 12'sd0;
        clr(); run(2048);
        chk("p4_h1l", h1l, 0);
        chk("p4_h2l", h2l, 2048);
        // P5: enable dropped mid-high-pulse, restored during the low phase
        run(500);
        chk("p5_pre_h1l", 32'(pwm1_l), 1);
        chk("p5_pre_h1r", 32'(pwm1_r), 1);
        en = 1'b0;
        run(1);
        chk("p5_en_h1l", 32'(pwm1_l), 0);
        chk("p5_en_h2l", 32'(pwm2_l), 0);
        chk("p5_en_h1r", 32'(pwm1_r), 0);
        run(529);
        en = 1'b1;
        clr(); run(1018);
        chk("p5_h1l", h1l, 0);
        chk("p5_h2l", h2l, 992);
        chk("p5_h1r", h1r, 494);
        chk("p5_h2r", h2r, 492);
        clr(); run(2048);
        chk("p6_h1l", h1l, 992);
        // Overcurrent: pulses inside the blanking window are ignored
        for (int i = 0; i < 5; i++) ovr_period(83, 1'b0, $sformatf("blank50_%0d", i));
        for (int i = 0; i < 3; i++) ovr_period(233, 1'b0, $sformatf("flag_a%0d", i));
        ovr_period(0, 1'b0, "clean");
        for (int i = 0; i < 3; i++) ovr_period(233, 1'b0, $sformatf("flag_b%0d", i));
        ovr_period(233, 1'b0, "pre_trip");
        clr();
        ovr_period(0, 1'b1, "trip");
        chk("trip_pwm_all", h1l + h2l + h1r + h2r, 0);
        ovr_period(0, 1'b1, "sticky");
        chk("overlap", ov_tot, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_shtdwn", 32'(shtdwn), 0);
        chk("async_rst_pwm", 32'({pwm1_l, pwm2_l, pwm1_r, pwm2_r}), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
